ifu_fetch: RTL

- Instruction fetch stage sitting directly upstream of the NPC decoder/control unit.
- Owns the PC and issues word fetches to instruction memory over a request/response handshake.
- Presents each fetched 32-bit instruction and its PC to the decoder via a valid/ready interface.
- Accepts redirects (jal/jalr/taken branch targets) from the execute stage and flags instruction-memory timeouts.

---
 rtl/ifu_fetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and hands each fetched word plus its PC to the decoder.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge.
// imem_resp_valid is never back-pressured. The decoder side uses
// inst_valid/inst_ready, and the memory request side uses
// imem_req_valid/imem_req_ready.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n;
    logic [31:0]   inst_n, inst_pc_n;
    logic          inst_valid_n, fetch_err_n;
    logic          drop, drop_n;
    logic [TW-1:0] tcnt, tcnt_n;

    logic [31:0]   redirect_target;
    logic          redirect_bad;
    logic          timed_out;

    // Misaligned targets are forced onto a word boundary and flagged.
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign redirect_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Once the counter hits TIMEOUT the stage parks in S_WAIT until reset.
    assign timed_out       = (tcnt == TMAX);

    assign imem_req_valid  = (state == S_REQ);
    assign imem_req_addr   = pc;

    // Next-state and datapath updates; every register holds unless told otherwise.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drop_n       = drop;
        tcnt_n       = tcnt;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_valid_n = inst_valid;
        fetch_err_n  = fetch_err | redirect_bad;

        // A redirect always retargets the PC; the latest one wins.
        if (redirect_valid) begin
            pc_n = redirect_target;
        end

        unique case (state)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_n = S_WAIT;
                    tcnt_n  = '0;
                    // The accepted request fetches the old PC, so its reply is stale.
                    if (redirect_valid) begin
                        drop_n = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (timed_out) begin
                    if (redirect_valid) begin
                        drop_n = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop || redirect_valid) begin
                        // Stale reply: throw it away and refetch from the new PC.
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        inst_n       = imem_resp_data;
                        inst_pc_n    = pc;
                        inst_valid_n = 1'b1;
                        state_n      = S_OUT;
                    end
                end else begin
                    tcnt_n = tcnt + TW'(1);
                    if (tcnt == TMAX - TW'(1)) begin
                        fetch_err_n = 1'b1;
                    end
                    if (redirect_valid) begin
                        drop_n = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    // Delivered; a same-cycle redirect replaces the sequential PC.
                    inst_valid_n = 1'b0;
                    state_n      = S_REQ;
                    if (!redirect_valid) begin
                        pc_n = pc + 32'd4;
                    end
                end else if (redirect_valid) begin
                    // Wrong-path instruction that the decoder never took.
                    inst_valid_n = 1'b0;
                    state_n      = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            drop       <= 1'b0;
            tcnt       <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_valid <= inst_valid_n;
            fetch_err  <= fetch_err_n;
            drop       <= drop_n;
            tcnt       <= tcnt_n;
        end
    end

endmodule
